// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared port indices, owner encoding and default widths for the data_ram arbiter
package data_ram_pkg;
  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {OWN_NONE, OWN_0, OWN_1} owner_e;
endpackage

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: round-robin two-port arbiter with bounded burst lock in front of a single-port RAM
module data_ram_arbiter
  import data_ram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  owner_e r_owner, w_owner_n, w_base_own;
  logic [CW-1:0] r_lock_cnt, w_cnt_n, w_base_cnt, w_cnt_inc;
  logic r_last, w_last_n, r_rvalid0, r_rvalid1;
  logic w_owner_req, w_hold, w_any, w_port, w_lock, w_we, w_drop, w_keep;
  // Pick the winning port and steer its fields onto the RAM pins; nothing is granted during reset
  always_comb begin
    w_owner_req = (r_owner == OWN_0) ? req0 : (r_owner == OWN_1) ? req1 : 1'b0;
    w_hold      = w_owner_req && (r_lock_cnt < CW'(MAX_LOCK));
    w_port      = w_hold ? (r_owner == OWN_1) : (req0 && req1) ? ~r_last : req1;
    w_any       = rst_n && (req0 || req1);
    gnt0        = w_any && !w_port;
    gnt1        = w_any && w_port;
    w_lock      = w_port ? lock1 : lock0;
    w_we        = w_port ? we1 : we0;
    ram_we      = w_any && w_we;
    ram_addr    = gnt1 ? addr1 : addr0;
    ram_wdata   = !w_any ? '0 : w_port ? wdata1 : wdata0;
    rvalid0     = r_rvalid0;
    rvalid1     = r_rvalid1;
    rdata0      = r_rvalid0 ? ram_rdata : '0;
    rdata1      = r_rvalid1 ? ram_rdata : '0;
  end
  // Ownership bookkeeping: an owner that dropped req is released first, then this cycle's grant is applied
  always_comb begin
    w_drop     = (r_owner != OWN_NONE) && !w_owner_req;
    w_base_own = w_drop ? OWN_NONE : r_owner;
    w_base_cnt = w_drop ? '0 : r_lock_cnt;
    w_cnt_inc  = (w_base_own == OWN_NONE) ? CW'(1) : w_base_cnt + CW'(1);
    w_keep     = w_lock && (w_cnt_inc != CW'(MAX_LOCK));
    w_owner_n  = !w_any ? w_base_own : !w_keep ? OWN_NONE : w_port ? OWN_1 : OWN_0;
    w_cnt_n    = !w_any ? w_base_cnt : w_keep ? w_cnt_inc : '0;
    w_last_n   = w_any ? w_port : w_drop ? (r_owner == OWN_1) : r_last;
  end
  // Arbitration state and read-return flags; reset makes port 0 win the first tie and drops pending returns
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_owner    <= OWN_NONE;
      r_lock_cnt <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_last     <= w_last_n;
      r_owner    <= w_owner_n;
      r_lock_cnt <= w_cnt_n;
      r_rvalid0  <= gnt0 && !we0;
      r_rvalid1  <= gnt1 && !we1;
    end
  end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed stimulus with a rule-level arbiter/RAM model checked every cycle
module tb_data_ram_arbiter;
  localparam int MAX_LOCK = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic req[2], we[2], lock[2];
  logic [7:0] addr[2], wdata[2];
  logic gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [7:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
  logic [7:0] ram[256];
  logic [7:0] mm[256];
  int checks = 0, errors = 0;
  int m_last, m_owner, m_cnt, mg, cg, k;
  bit m_rv[2];
  bit m_ready = 1'b0;
  logic [7:0] m_rd;
  logic [7:0] bexp;

  data_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .lock0(lock[0]), .lock1(lock[1]), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // data_ram: registered read, read-before-write on the same edge
  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (rst_n !== 1'b1) return -1;
    if (m_owner >= 0 && req[m_owner] && m_cnt < MAX_LOCK) return m_owner;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    mg = pick();
    if (rst_n !== 1'b1) begin
      m_last = 1; m_owner = -1; m_cnt = 0; m_rv[0] = 0; m_rv[1] = 0;
    end else begin
      if (m_owner >= 0 && !req[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_cnt = 0;
      end
      m_rv[0] = (mg == 0) && !we[0];
      m_rv[1] = (mg == 1) && !we[1];
      if (mg >= 0) begin
        m_rd = mm[addr[mg]];
        if (we[mg]) mm[addr[mg]] = wdata[mg];
        m_last = mg;
        if (!lock[mg]) begin
          m_owner = -1; m_cnt = 0;
        end else begin
          m_owner = mg; m_cnt++;
          if (m_cnt == MAX_LOCK) begin m_owner = -1; m_cnt = 0; end
        end
      end
    end
    m_ready = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      cg = pick();
      chk("m_gnt0", gnt0, cg == 0);
      chk("m_gnt1", gnt1, cg == 1);
      chk("m_ram_we", ram_we, (cg >= 0) ? we[cg] : 1'b0);
      chk("m_ram_addr", ram_addr, (cg >= 0) ? addr[cg] : addr[0]);
      chk("m_ram_wdata", ram_wdata, (cg >= 0) ? wdata[cg] : 8'h00);
      chk("m_rvalid0", rvalid0, m_rv[0]);
      chk("m_rvalid1", rvalid1, m_rv[1]);
      chk("m_rdata0", rdata0, m_rv[0] ? m_rd : 8'h00);
      chk("m_rdata1", rdata1, m_rv[1] ? m_rd : 8'h00);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; lock[p] = 0; addr[p] = 8'h00; wdata[p] = 8'h00;
    end
  endtask

  task automatic drv(int p, bit r, bit w, logic [7:0] a, logic [7:0] d, bit l);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d; lock[p] = l;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; mm[i] = 8'h00; end
    ram[1] = 8'h11; mm[1] = 8'h11;
    ram[2] = 8'h22; mm[2] = 8'h22;
    rst_n = 1'b0;
    idle();
    drv(0, 1, 1, 8'h00, 8'h00, 0);
    cyc();
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rvalid0", rvalid0, 0);
    cyc();
    rst_n = 1'b1;
    idle(); drv(0, 1, 1, 8'h10, 8'h5A, 0);
    @(negedge clk);
    chk("wr_gnt0", gnt0, 1);
    chk("wr_ram_addr", ram_addr, 8'h10);
    cyc();
    idle(); drv(0, 1, 0, 8'h10, 8'h00, 0);
    @(negedge clk);
    chk("rd_gnt0", gnt0, 1);
    cyc();
    idle();
    @(negedge clk);
    chk("rd_rvalid0", rvalid0, 1);
    chk("rd_rdata0", rdata0, 8'h5A);
    chk("rd_rvalid1", rvalid1, 0);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin drv(0, 1, 0, 8'h01, 8'h00, 0); drv(1, 1, 0, 8'h02, 8'h00, 0); end
      @(negedge clk);
      if (i < 4) begin
        chk("rr_gnt0", gnt0, i % 2 == 0);
        chk("rr_gnt1", gnt1, i % 2 == 1);
      end
      if (i % 2 == 1) begin
        chk("rr_rvalid0", rvalid0, 1);
        chk("rr_rdata0", rdata0, 8'h11);
      end else if (i > 0) begin
        chk("rr_rvalid1", rvalid1, 1);
        chk("rr_rdata1", rdata1, 8'h22);
      end
      cyc();
    end
    idle(); drv(0, 1, 1, 8'h30, 8'h33, 0);
    @(negedge clk);
    chk("pre_gnt0", gnt0, 1);
    cyc();
    bexp = 8'b11110110;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      idle(); drv(0, 1, 0, 8'h01, 8'h00, 0);
      if (k < 6) drv(1, 1, 1, 8'h40 + 8'(k), 8'hA0 + 8'(k), 1);
      @(negedge clk);
      chk("burst_gnt1", gnt1, bexp[7-c]);
      chk("burst_gnt0", gnt0, !bexp[7-c]);
      if (gnt1) k++;
      cyc();
    end
    chk("burst_count", k, 6);
    idle(); drv(0, 1, 1, 8'h20, 8'h77, 0);
    @(negedge clk);
    chk("raw_gnt0", gnt0, 1);
    cyc();
    idle(); drv(1, 1, 0, 8'h20, 8'h00, 0);
    @(negedge clk);
    chk("raw_gnt1", gnt1, 1);
    cyc();
    idle();
    @(negedge clk);
    chk("raw_rvalid1", rvalid1, 1);
    chk("raw_rdata1", rdata1, 8'h77);
    cyc();
    drv(1, 1, 0, 8'h02, 8'h00, 1);
    @(negedge clk);
    chk("lk_gnt1", gnt1, 1);
    cyc();
    rst_n = 1'b0;
    drv(0, 1, 0, 8'h01, 8'h00, 0);
    @(negedge clk);
    chk("mid_rst_gnt1", gnt1, 0);
    chk("mid_rst_ram_we", ram_we, 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid1", rvalid1, 0);
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);
    cyc();
    idle(); drv(0, 1, 1, 8'h50, 8'h01, 1);
    @(negedge clk);
    chk("own_first_gnt0", gnt0, 1);
    cyc();
    drv(0, 1, 1, 8'h51, 8'h02, 1); drv(1, 1, 0, 8'h50, 8'h00, 0);
    @(negedge clk);
    chk("own_gnt0", gnt0, 1);
    chk("own_blk_gnt1", gnt1, 0);
    cyc();
    req[0] = 0;
    @(negedge clk);
    chk("drop_gnt1", gnt1, 1);
    chk("drop_gnt0", gnt0, 0);
    cyc();
    idle();
    @(negedge clk);
    chk("drop_rdata1", rdata1, 8'h01);
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
